// File: rtl/vga_line_buffer.sv
// Double-buffered NES->VGA scanline buffer: 2x horizontal scaling, each NES line shown on two rows.
// Optional `VGA_SCANLINE_EN halves in-window colour channels on odd display rows.
module vga_line_buffer #(
    parameter int               LINE_W     = 256,
    parameter int               H_OFFSET   = 64,
    parameter int               PIX_W      = 12,
    parameter logic [PIX_W-1:0] BORDER_RGB = 12'h000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       h_count,
    input  logic [9:0]       v_count,
    input  logic             video_on,
    input  logic             wr_valid,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ready,
    output logic             line_req,
    output logic             underrun,
    output logic [PIX_W-1:0] rgb
);
    localparam int            AW       = $clog2(LINE_W);
    localparam int            CW       = PIX_W / 3;
    localparam logic [9:0]    WIN_LO   = 10'(H_OFFSET);
    localparam logic [9:0]    WIN_HI   = 10'(H_OFFSET + 2 * LINE_W);
    localparam logic [9:0]    V_ACTIVE = 10'd480;
    localparam logic [AW-1:0] LAST_IDX = AW'(LINE_W - 1);

    logic [PIX_W-1:0] bank0_r [LINE_W];
    logic [PIX_W-1:0] bank1_r [LINE_W];
    logic [PIX_W-1:0] rd_data_r;
    logic             rd_sel_r;
    logic             rd_valid_r;
    logic             pend_full_r;
    logic             started_r;
    logic             line_req_r;
    logic             underrun_r;
    logic [AW-1:0]    wr_idx_r;
    logic [9:0]       h_prev_r;
    logic             von_d_r;
    logic             win_d_r;
    logic [PIX_W-1:0] rgb_r;
    logic [PIX_W-1:0] rgb_next_s;
    logic             line_edge_s;
    logic             swap_s;
    logic             release_s;
    logic             accept_s;
    logic             in_window_s;
    logic [AW-1:0]    rd_addr_s;
`ifdef VGA_SCANLINE_EN
    logic             odd_d_r;

    function automatic logic [PIX_W-1:0] halve_rgb(input logic [PIX_W-1:0] pix);
        logic [PIX_W-1:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            res[c*CW +: CW] = pix[c*CW +: CW] >> 1;
        end
        return res;
    endfunction
`endif

    // Line-start events, write handshake and read address decode
    always_comb begin
        line_edge_s = (h_count == 10'd0) && (h_prev_r != 10'd0);
        swap_s      = line_edge_s && !v_count[0] && (v_count < V_ACTIVE);
        release_s   = line_edge_s && (v_count == V_ACTIVE);
        accept_s    = wr_valid && !pend_full_r;
        in_window_s = (h_count >= WIN_LO) && (h_count < WIN_HI);
        rd_addr_s   = AW'((h_count - WIN_LO) >> 1);
    end

    // Pixel write into whichever bank is not on display
    always_ff @(posedge clk) begin
        if (accept_s && rd_sel_r) bank0_r[wr_idx_r] <= wr_data;
        if (accept_s && !rd_sel_r) bank1_r[wr_idx_r] <= wr_data;
    end

    // Synchronous read from the display bank (first pipeline stage)
    always_ff @(posedge clk) begin
        if (rd_sel_r) rd_data_r <= bank1_r[rd_addr_s];
        else          rd_data_r <= bank0_r[rd_addr_s];
    end

    // Bank ownership, fill tracking and line request generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sel_r    <= 1'b0;
            rd_valid_r  <= 1'b0;
            pend_full_r <= 1'b0;
            started_r   <= 1'b0;
            line_req_r  <= 1'b0;
            underrun_r  <= 1'b0;
            wr_idx_r    <= '0;
            h_prev_r    <= 10'd0;
        end else begin
            h_prev_r   <= h_count;
            started_r  <= 1'b1;
            // The very first cycle out of reset asks for the first line.
            line_req_r <= !started_r || (swap_s && pend_full_r);
            if (swap_s && pend_full_r) begin
                rd_sel_r    <= !rd_sel_r;
                rd_valid_r  <= 1'b1;
                pend_full_r <= 1'b0;
            end else if (swap_s) begin
                rd_valid_r  <= 1'b0;
                underrun_r  <= 1'b1;
            end else if (release_s) begin
                rd_valid_r  <= 1'b0;
            end
            if (accept_s) begin
                if (wr_idx_r == LAST_IDX) begin
                    wr_idx_r    <= '0;
                    pend_full_r <= 1'b1;
                end else begin
                    wr_idx_r    <= wr_idx_r + AW'(1);
                end
            end
        end
    end

    // Output colour selection for the second pipeline stage
    always_comb begin
        rgb_next_s = BORDER_RGB;
        if (!von_d_r) begin
            rgb_next_s = '0;
        end else if (win_d_r && rd_valid_r) begin
`ifdef VGA_SCANLINE_EN
            if (odd_d_r) rgb_next_s = halve_rgb(rd_data_r);
            else         rgb_next_s = rd_data_r;
`else
            rgb_next_s = rd_data_r;
`endif
        end else begin
            rgb_next_s = BORDER_RGB;
        end
    end

    // Qualifiers delayed to line up with the RAM read, then the output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            von_d_r <= 1'b0;
            win_d_r <= 1'b0;
`ifdef VGA_SCANLINE_EN
            odd_d_r <= 1'b0;
`endif
            rgb_r   <= '0;
        end else begin
            von_d_r <= video_on;
            win_d_r <= in_window_s;
`ifdef VGA_SCANLINE_EN
            odd_d_r <= v_count[0];
`endif
            rgb_r   <= rgb_next_s;
        end
    end

    assign wr_ready = !pend_full_r;
    assign line_req = line_req_r;
    assign underrun = underrun_r;
    assign rgb      = rgb_r;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Self-checking bench for vga_line_buffer: vector table, hand-written corner sequences and a
// per-cycle reference model of the line buffer built from arrays and plain arithmetic.
module tb_vga_line_buffer;
    localparam logic [11:0] BORDER = 12'h000;
`ifdef VGA_SCANLINE_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  h_count = 10'd0;
    logic [9:0]  v_count = 10'd0;
    logic        video_on = 1'b0;
    logic        wr_valid = 1'b0;
    logic [11:0] wr_data = 12'h000;
    logic        wr_ready;
    logic        line_req;
    logic        underrun;
    logic [11:0] rgb;

    vga_line_buffer dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .video_on(video_on),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .line_req(line_req),
        .underrun(underrun), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [11:0] m_bank [2][256];
    int          m_sel, m_widx, m_hprev;
    bit          m_valid, m_pend, m_under, m_started, m_req;
    bit          s_von, s_win, s_odd;
    logic [11:0] s_pix;
    logic [11:0] m_rgb;
    int          feed_mode = 0;
    bit          counting = 1'b0;
    int          req_count = 0;

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        bit          von;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] halve(input logic [11:0] p);
        return (p >> 1) & 12'h777;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_widx = 0; m_hprev = 0;
        m_valid = 0; m_pend = 0; m_under = 0; m_started = 0; m_req = 0;
        s_von = 0; s_win = 0; s_odd = 0; s_pix = 12'h000; m_rgb = 12'h000;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge
    task automatic model_edge();
        bit ev, swap, rel, acc, pend0;
        int addr;
        if (!s_von) m_rgb = 12'h000;
        else if (s_win && m_valid) m_rgb = (SCAN && s_odd) ? halve(s_pix) : s_pix;
        else m_rgb = BORDER;
        s_von = video_on;
        s_win = (h_count >= 10'd64) && (h_count < 10'd576);
        s_odd = v_count[0];
        addr  = s_win ? (int'(h_count) - 64) / 2 : 0;
        s_pix = m_bank[m_sel][addr];
        ev    = (h_count == 10'd0) && (m_hprev != 0);
        swap  = ev && (v_count % 2 == 0) && (v_count < 10'd480);
        rel   = ev && (v_count == 10'd480);
        pend0 = m_pend;
        acc   = wr_valid && !pend0;
        m_req = !m_started || (swap && pend0);
        if (acc) begin
            m_bank[1 - m_sel][m_widx] = wr_data;
            m_widx = (m_widx + 1) % 256;
            if (m_widx == 0) m_pend = 1;
        end
        if (swap && pend0) begin
            m_sel = 1 - m_sel; m_valid = 1; m_pend = 0;
        end else if (swap) begin
            m_valid = 0; m_under = 1;
        end else if (rel) begin
            m_valid = 0;
        end
        m_hprev = int'(h_count);
        m_started = 1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        if (counting && line_req) req_count++;
        check("rgb", rgb, m_rgb);
        check("wr_ready", wr_ready, !m_pend);
        check("line_req", line_req, m_req);
        check("underrun", underrun, m_under);
        if (feed_mode == 1) begin
            wr_valid = 1'b1; wr_data = 12'($urandom);
        end else if (feed_mode == 2) begin
            wr_valid = ($urandom % 4) != 0; wr_data = 12'($urandom);
        end
    endtask

    task automatic run_line(input int v, input int h0, input int len);
        for (int h = h0; h < len; h++) begin
            h_count = 10'(h); v_count = 10'(v);
            video_on = (h < 640) && (v <= 480);
            step();
        end
    endtask

    task automatic hold(input int h, input int v, input bit von);
        h_count = 10'(h); v_count = 10'(v); video_on = von;
        step(); step();
    endtask

    task automatic fill(input bit use_const, input logic [11:0] val);
        h_count = 10'd700; v_count = 10'd524; video_on = 1'b0; feed_mode = 0;
        for (int i = 0; i < 256; i++) begin
            wr_valid = 1'b1; wr_data = use_const ? val : 12'(i);
            step();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int b = 0; b < 2; b++) for (int i = 0; i < 256; i++) m_bank[b][i] = 12'h000;
        tbl[0] = '{10'd64,  10'd0, 1'b1, 12'h000};
        tbl[1] = '{10'd65,  10'd0, 1'b1, 12'h000};
        tbl[2] = '{10'd66,  10'd0, 1'b1, 12'h001};
        tbl[3] = '{10'd575, 10'd0, 1'b1, 12'h0FF};
        tbl[4] = '{10'd63,  10'd0, 1'b1, BORDER};
        tbl[5] = '{10'd576, 10'd0, 1'b1, BORDER};
        tbl[6] = '{10'd300, 10'd0, 1'b0, 12'h000};
        tbl[7] = '{10'd300, 10'd1, 1'b1, SCAN ? 12'h033 : 12'h076};

        // Reset state
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_rgb", rgb, 12'h000);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_underrun", underrun, 1'b0);
        check("rst_line_req", line_req, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("boot_req_hi", line_req, 1'b1);
        step();
        check("boot_req_lo", line_req, 1'b0);

        // Fill with index data; a 257th pixel is refused
        fill(1'b0, 12'h000);
        check("fill_ready_lo", wr_ready, 1'b0);
        wr_valid = 1'b1; wr_data = 12'hABC;
        step();
        check("extra_refused", wr_ready, 1'b0);
        wr_valid = 1'b0;

        // First display line and window vectors
        run_line(0, 0, 1);
        check("swap0_req", line_req, 1'b1);
        check("swap0_ready", wr_ready, 1'b1);
        run_line(0, 1, 660);
        for (int i = 0; i < 8; i++) begin
            hold(int'(tbl[i].h), int'(tbl[i].v), tbl[i].von);
            check($sformatf("tbl%0d", i), rgb, tbl[i].exp_rgb);
        end

        // Underrun at v=2, refill with random gaps, v=4 recovers
        run_line(1, 0, 660);
        run_line(2, 0, 1);
        check("underrun_set", underrun, 1'b1);
        run_line(2, 1, 660);
        hold(300, 2, 1'b1);
        check("underrun_v2_border", rgb, BORDER);
        feed_mode = 2;
        run_line(3, 0, 660);
        hold(300, 3, 1'b1);
        check("underrun_v3_border", rgb, BORDER);
        feed_mode = 1; h_count = 10'd700; video_on = 1'b0;
        begin
            int k = 0;
            while (wr_ready && k < 300) begin step(); k++; end
        end
        check("refill_done", wr_ready, 1'b0);
        feed_mode = 0; wr_valid = 1'b0;
        run_line(4, 0, 1);
        check("swap4_req", line_req, 1'b1);
        check("underrun_sticky", underrun, 1'b1);
        feed_mode = 2;
        run_line(4, 1, 660);
        for (int v = 5; v < 10; v++) run_line(v, 0, 660);

        // End of active area, release and blanking
        for (int v = 478; v <= 480; v++) run_line(v, 0, 660);
        hold(300, 480, 1'b1);
        check("release_border", rgb, BORDER);
        hold(300, 480, 1'b0);
        check("blank_zero", rgb, 12'h000);
        feed_mode = 1;
        for (int v = 481; v < 525; v++) run_line(v, 0, 2);

        // One compressed frame: count line requests
        counting = 1'b1; req_count = 0;
        for (int v = 0; v < 525; v++) run_line(v, 0, (v < 480 && v % 2 == 0) ? 258 : 2);
        counting = 1'b0;
        check("frame_req_count", req_count, 240);

        // Reset mid-operation, then scanline behaviour on a constant white line
        feed_mode = 0; wr_valid = 1'b1; wr_data = 12'h123;
        h_count = 10'd300; v_count = 10'd100; video_on = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_rgb", rgb, 12'h000);
        check("midrst_wr_ready", wr_ready, 1'b1);
        check("midrst_line_req", line_req, 1'b0);
        check("midrst_underrun", underrun, 1'b0);
        wr_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        check("midrst_boot_req", line_req, 1'b1);
        fill(1'b1, 12'hFFF);
        run_line(0, 0, 660);
        hold(200, 0, 1'b1);
        check("scan_even", rgb, 12'hFFF);
        hold(200, 1, 1'b1);
        check("scan_odd", rgb, SCAN ? 12'h777 : 12'hFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_line_buffer.md
# vga_line_buffer

Double-buffered scanline buffer between the NES PPU pixel stream and the VGA scan-out stage. Each 256-pixel NES line arrives from the PPU over a valid/ready write port. The line is shown on two consecutive 640×480 display lines with 2× horizontal replication and 64-pixel side borders. RGB output is produced from the VGA timing generator's `h_count`/`v_count`/`video_on`.

## Interface
- `LINE_W`, 256: NES pixels per line; bank depth.
- `H_OFFSET`, 64: first active display column of the scaled window.
- `PIX_W`, 12: pixel width, 4:4:4 RGB.
- `BORDER_RGB`, 12'h000: colour outside the window, and colour when no line is valid.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-low reset.
- `h_count` in 10: display column from the timing generator.
- `v_count` in 10: display row from the timing generator.
- `video_on` in 1: active-display qualifier from the timing generator.
- `wr_valid` in 1: PPU pixel valid.
- `wr_data` in PIX_W: PPU pixel.
- `wr_ready` out 1: write bank can accept a pixel.
- `line_req` out 1: one-cycle pulse meaning the write bank was just freed and the next NES line should be sent.
- `underrun` out 1: sticky; a swap found no complete line.
- `rgb` out PIX_W: pixel to the DAC pins.

## Operation
- **Storage:** two banks of `LINE_W`×`PIX_W`. `rd_sel` selects the display bank; the write bank is always `~rd_sel`.
- **State:** `rd_valid` (display bank holds a line), `pend_full` (write bank complete), `wr_idx` (8-bit), `h_prev` (registered `h_count`).
- **Write:** a pixel is accepted when `wr_valid && wr_ready`, with `wr_ready = !pend_full`.
  - Accepted pixel is stored at `wr_idx`, then `wr_idx` increments.
  - On the accept at `wr_idx==LINE_W-1`: `wr_idx` wraps to 0 and `pend_full` is set.
  - `wr_valid` is ignored while `wr_ready` is low.
- **Swap event:** fires when `h_count==0 && h_prev!=0 && v_count[0]==0 && v_count<480`. One event per line, independent of the pixel-clock enable rate.
  - If `pend_full`: toggle `rd_sel`, set `rd_valid=1`, clear `pend_full`, pulse `line_req`.
  - Otherwise: set `rd_valid=0` and `underrun=1`. The write bank is untouched, so a partial fill continues.
- **Release event:** `h_count==0 && h_prev!=0 && v_count==480` sets `rd_valid=0`. No `line_req` is generated.
- **Read path:**
  - Window is `H_OFFSET <= h_count < H_OFFSET+2*LINE_W`.
  - Read address is `(h_count-H_OFFSET)>>1`, truncated to 8 bits.
  - Output: if delayed `video_on` is 0, `rgb=0`. Else, if delayed window && `rd_valid`, `rgb`=bank pixel. Else `rgb=BORDER_RGB`.
- **Frame sequence:** exactly 240 swaps per frame and 240 `line_req` pulses per frame. The request after the v=478 swap fetches line 0 of the next frame during vblank.

## Timing
- **Reset values:**
  - Outputs: `rgb=0`, `wr_ready=1`, `line_req=0`, `underrun=0`.
  - Internal: `rd_valid=0`, `pend_full=0`, `wr_idx=0`, `rd_sel=0`, `h_prev=0`.
- **Reset release:** `line_req` pulses exactly once, on the first clock edge after `rst` deasserts. This requests the first line.
- **Read latency:** 2 cycles from `h_count`/`video_on` to `rgb` (synchronous RAM read, then output register). Window and `video_on` are pipelined to match. The integrator delays `h_sync`/`v_sync` by 2 cycles.
- **Write:** the 256th accept drives `wr_ready` low on the next cycle. `wr_ready` returns high the cycle after a successful swap.
- **`line_req`:** registered, asserted the cycle after the swap edge, one cycle wide.
- **Simultaneous events:**
  - 256th write in the same cycle as a swap: the swap sees the pre-edge `pend_full=0`, so it underruns. That line displays from the next swap.
  - Write into the write bank in the same cycle as a display read: no conflict, because the banks are distinct.
- **Reset mid-operation:** all state is cleared immediately (asynchronous) and any partial line is discarded.

## Configuration
- `VGA_SCANLINE_EN` defined: on odd `v_count` (delayed), in-window pixel channels are each halved (`{r>>1,g>>1,b>>1}`). Border and blanking are unaffected.
- Undefined: odd and even lines are identical.

## Test plan
- **Reset:** hold `rst=0` → `rgb=0`, `wr_ready=1`, `underrun=0`. Release → `line_req` high for exactly 1 cycle.
- **Fill:** send 256 pixels, `wr_data`=index → `wr_ready` low after the last accept. A 257th `wr_valid` is not accepted and `wr_idx` stays 0.
- **First display line:** swap at v=0.
  - `line_req` pulses.
  - h=64 and 65 → `rgb`=12'h000 (pixel 0) 2 cycles later.
  - h=66 → 12'h001.
  - h=575 → 12'h0FF.
  - h=63 and h=576 → `BORDER_RGB`.
- **Underrun:** leave the write bank unfilled at the v=2 swap → `underrun=1` sticky. Window shows `BORDER_RGB` on v=2 and 3. Fill, then the v=4 swap succeeds.
- **Blanking and release:** `video_on=0` → `rgb=0`. At v=480 the window shows `BORDER_RGB`. Count 240 `line_req` pulses per frame.
- **`VGA_SCANLINE_EN`:** fill with 12'hFFF → v=0 shows 12'hFFF and v=1 shows 12'h777.
